avalon_mem_responder: RTL and testbench

//  Avalon-MM slave memory. It is the responder end of the SDRAM master port driven by the wordcopy accelerator.
//  It services pipelined reads with fixed latency and readdatavalid, byte-enabled writes, and waitrequest back-pressure.
//  The storage is a behavioural/BRAM word array.
//  It sits between a DMA-style master (wordcopy, later accelerators) and on-chip memory.
//  It also serves as the bench SDRAM stand-in.

---
 rtl/avalon_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_avalon_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : avalon_mem_responder
// Description : Avalon-MM slave word memory. It is the responder for a
//               DMA-style master such as wordcopy, and it also serves as an
//               SDRAM stand-in on the bench.
//               - Pipelined reads with a fixed latency of READ_LAT cycles,
//                 returned in order on s_readdatavalid.
//               - Byte-enabled writes that complete in the accept cycle.
//               - Back-pressure on s_waitrequest when MAX_PEND reads are
//                 outstanding, and while rst is high.
//               - Sticky err_flag on an out-of-range access, or when read and
//                 write are asserted together.
// Ports       : clk, rst (synchronous, active-high)
//               s_address[31:0], s_read, s_write, s_writedata[31:0],
//               s_byteenable[3:0]                               -> inputs
//               s_waitrequest, s_readdata[31:0], s_readdatavalid,
//               err_flag                                        -> outputs
// Option      : `define WAIT_INJECT_EN adds pseudo-random stall injection
//               from a 16-bit LFSR that is ORed into s_waitrequest.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_mem_responder #(
    parameter int unsigned DEPTH     = 1024,      // number of 32-bit words
    parameter logic [31:0] BASE_ADDR = 32'h0,     // byte address of word 0, 4-byte aligned
    parameter int unsigned READ_LAT  = 2,         // read accept -> readdatavalid, 1..8
    parameter int unsigned MAX_PEND  = 3,         // max outstanding reads, >= 1
    parameter logic [15:0] LFSR_SEED = 16'hACE1   // stall-injection seed, nonzero
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic [3:0]  s_byteenable,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid,
    output logic        err_flag
);

    localparam int unsigned   c_idx_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   c_pend_w   = $clog2(MAX_PEND + 1);
    localparam logic [c_pend_w-1:0] c_max_pend = c_pend_w'(MAX_PEND);
    localparam logic [c_pend_w-1:0] c_pend_one = c_pend_w'(1);
    localparam logic [31:0]   c_oor_data = 32'hDEADBEEF;

    // ------------------------------------------------------------------
    // Address decode. The offset is computed one bit wider so that an
    // address below BASE_ADDR shows up as a borrow in bit 32; this also
    // keeps BASE_ADDR + 4*DEPTH from wrapping at the top of the map.
    // ------------------------------------------------------------------
    logic [32:0]          w_off;
    logic                 w_in_range;
    logic [c_idx_w-1:0]   w_idx;

    assign w_off      = {1'b0, s_address} - {1'b0, BASE_ADDR};
    assign w_in_range = ~w_off[32] && ({2'b00, w_off[31:2]} < 32'(DEPTH));
    assign w_idx      = w_off[c_idx_w+1:2];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic                 w_pend_full;
    logic                 w_accept;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_err_evt;
    logic [c_pend_w-1:0]  r_pend;

    assign w_pend_full = (r_pend == c_max_pend);

`ifdef WAIT_INJECT_EN
    // 16-bit Fibonacci LFSR, taps 16,14,13,11. It free-runs and only adds
    // stalls. Reads that are already accepted keep their fixed latency.
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic        w_inject;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_inject  = (r_lfsr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign s_waitrequest = rst | w_pend_full | w_inject;
`else
    logic w_unused_seed;
    assign w_unused_seed = ^LFSR_SEED;

    assign s_waitrequest = rst | w_pend_full;
`endif

    // A single waitrequest gates reads and writes alike, so a write can
    // never overtake a stalled read, or the reverse.
    assign w_accept  = (s_read | s_write) & ~s_waitrequest;
    // Read and write together are treated as the write alone.
    assign w_rd_acc  = w_accept & s_read & ~s_write;
    assign w_wr_acc  = w_accept & s_write & w_in_range;
    assign w_err_evt = w_accept & (~w_in_range | (s_read & s_write));

    // ------------------------------------------------------------------
    // Storage. Reset does not clear it, so the contents survive rst.
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];
    logic [31:0] w_rd_word;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteenable[b]) begin
                    r_mem[w_idx][8*b +: 8] <= s_writedata[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured in the accept cycle. A write accepted later
    // therefore cannot change data that is already in flight, and a read
    // that follows a write to the same word sees the new value.
    assign w_rd_word = w_in_range ? r_mem[w_idx] : c_oor_data;

    // ------------------------------------------------------------------
    // Read return pipe: stage k holds {valid, data}, and the last stage
    // drives the outputs directly. A reset empties it, so reads that are
    // in flight at reset never return.
    // ------------------------------------------------------------------
    logic        r_vld [READ_LAT];
    logic [31:0] r_dat [READ_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < READ_LAT; k++) begin
                r_vld[k] <= 1'b0;
                r_dat[k] <= 32'h0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            r_dat[0] <= w_rd_acc ? w_rd_word : 32'h0;
            for (int k = 1; k < READ_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_dat[k] <= r_dat[k-1];
            end
        end
    end

    assign s_readdatavalid = r_vld[READ_LAT-1];
    assign s_readdata      = r_dat[READ_LAT-1];

    // ------------------------------------------------------------------
    // Outstanding-read counter. It decrements while a response is on the
    // bus. That response slot is still held, so sustained one-per-cycle
    // reads need MAX_PEND >= READ_LAT + 1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            case ({w_rd_acc, s_readdatavalid})
                2'b10:   r_pend <= r_pend + c_pend_one;
                2'b01:   r_pend <= r_pend - c_pend_one;
                default: r_pend <= r_pend;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign err_flag = r_err;

    // Byte-lane bits of the offset are not part of the word index.
    logic w_unused_lane;
    assign w_unused_lane = ^w_off[1:0];

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_mem_responder
// Description : Self-checking bench for avalon_mem_responder.
//               - A driver issues Avalon requests and pushes the expected
//                 read responses into a queue. Those expectations come from
//                 an array model of the memory.
//               - A monitor pops the queue on every s_readdatavalid and
//                 checks the data and the latency. It also checks err_flag
//                 on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          RL    = 2;
    localparam int          MP    = 3;
    localparam int          c_INF = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_address    = '0;
    logic        s_read       = 1'b0;
    logic        s_write      = 1'b0;
    logic [31:0] s_writedata  = '0;
    logic [3:0]  s_byteenable = '0;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        err_flag;

    always #5 clk = ~clk;

    avalon_mem_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .READ_LAT  (RL),
        .MAX_PEND  (MP),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .err_flag        (err_flag)
    );

    // Posedge count. Reads of it at a negedge are stable.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference model and scoreboard
    logic [31:0] model [DEPTH];
    logic [31:0] q_data [$];
    int          q_edge [$];
    int          err_edge     = c_INF;   // first edge at which err_flag must be set
    int          n_checks     = 0;
    int          n_pass       = 0;
    int          total_stalls = 0;
    int          last_stalls  = 0;
    int          n_valid      = 0;
    logic [31:0] last_rd      = '0;
    logic [31:0] mon_exp;
    int          mon_edge;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model update for one accepted request, applied before its accept edge.
    task automatic model_accept(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be);
        longint unsigned a   = longint'(addr);
        longint unsigned lo  = longint'(BASE);
        longint unsigned hi  = longint'(BASE) + 4 * longint'(DEPTH);
        bit              inr = (a >= lo) && (a < hi);
        int              idx = inr ? int'((a - lo) / 4) : 0;
        int              acc = edge_n + 1;
        if (wr) begin
            if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
            if (!inr || rd) err_edge = (acc < err_edge) ? acc : err_edge;
        end else if (rd) begin
            q_data.push_back(inr ? model[idx] : 32'hDEADBEEF);
            q_edge.push_back(acc);
            if (!inr) err_edge = (acc < err_edge) ? acc : err_edge;
        end
    endtask

    // Drive a request at a negedge, hold it through waitrequest, and return
    // at the negedge that follows the accept edge.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        int guard = 0;
        s_read = rd; s_write = wr; s_address = addr; s_writedata = data; s_byteenable = be;
        while (s_waitrequest && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        last_stalls   = guard;
        total_stalls += guard;
        if (guard >= 100) begin
            n_checks++;
            $display("FAIL accept_timeout: waitrequest=%0b after %0d cycles, required 0", s_waitrequest, guard);
        end else begin
            model_accept(rd, wr, addr, data, be);
        end
        @(negedge clk);
        s_read  = 1'b0;
        s_write = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q_data.size() > 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("drain_outstanding", 32'(q_data.size()), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; s_read = 1'b0; s_write = 1'b0;
        q_data.delete();
        q_edge.delete();
        @(negedge clk);
        chk("rst_readdatavalid", 32'(s_readdatavalid), 32'd0);
        chk("rst_readdata",      s_readdata,           32'd0);
        chk("rst_err_flag",      32'(err_flag),        32'd0);
        chk("rst_waitrequest",   32'(s_waitrequest),   32'd1);
        repeat (cycles - 1) @(negedge clk);
        err_edge = c_INF;
        rst = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (s_readdatavalid) begin
                n_valid++;
                last_rd = s_readdata;
                if (q_data.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: readdatavalid=1 data %h, required no response", s_readdata);
                end else begin
                    mon_exp  = q_data.pop_front();
                    mon_edge = q_edge.pop_front();
                    chk("rd_data", s_readdata, mon_exp);
                    chk("rd_latency", 32'(edge_n + 1 - mon_edge), 32'(RL));
                end
            end
            chk("err_flag", 32'(err_flag), 32'(edge_n >= err_edge));
        end
    end

    initial begin
        int          r;
        int          nv;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;

        do_reset(3);

        // Fill the whole memory so that every later read has a known value.
        for (int i = 0; i < DEPTH; i++)
            issue(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

        // Full write then readback
        issue(1'b0, 1'b1, BASE + 32'h10, 32'hCAFEF00D, 4'hF);
        issue(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
        drain();
        chk("t1_readback", last_rd, 32'hCAFEF00D);

        // Byte-enable merge
        issue(1'b0, 1'b1, BASE + 32'h20, 32'hAAAAAAAA, 4'hF);
        issue(1'b0, 1'b1, BASE + 32'h20, 32'h11223344, 4'b0101);
        issue(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
        drain();
        chk("t2_byteenable", last_rd, 32'hAA22AA44);

        // Back-to-back reads: with MAX_PEND >= READ_LAT+1 there are no stalls.
        r = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0);
            r += last_stalls;
        end
        drain();
`ifndef WAIT_INJECT_EN
        chk("t3_burst_stalls", 32'(r), 32'd0);
`endif

        // Out-of-range read and write
        issue(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0);
        drain();
        chk("t4_oor_data", last_rd, 32'hDEADBEEF);
        issue(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'h12345678, 4'hF);
        issue(1'b1, 1'b0, BASE, 32'h0, 4'h0);
        drain();
        chk("t4_err_sticky", 32'(err_flag), 32'd1);

        // Reset while a read is in flight
        issue(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
        nv = n_valid;
        do_reset(2);
        repeat (6) @(negedge clk);
        chk("t5_no_valid_after_rst", 32'(n_valid), 32'(nv));
        issue(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
        drain();
        chk("t5_mem_kept", last_rd, 32'hCAFEF00D);

        // Wordcopy-style copy 0x100 -> 0x200
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 1'b0, BASE + 32'h100 + 32'(4 * i), 32'h0, 4'h0);
            drain();
            issue(1'b0, 1'b1, BASE + 32'h200 + 32'(4 * i), last_rd, 4'hF);
            model[(32'h200 >> 2) + i] = model[(32'h100 >> 2) + i];
        end
        for (int i = 0; i < 16; i++)
            issue(1'b1, 1'b0, BASE + 32'h200 + 32'(4 * i), 32'h0, 4'h0);
        drain();
`ifdef WAIT_INJECT_EN
        chk("t6_saw_waitrequest", 32'(total_stalls > 0), 32'd1);
`endif

        // Randomized traffic over a small window, with out-of-range and
        // dual-command accesses mixed in
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 99);
            a  = BASE + 32'(4 * $urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            if (r < 45)      issue(1'b1, 1'b0, a, d, be);
            else if (r < 95) issue(1'b0, 1'b1, a, d, be);
            else             issue(1'b1, 1'b1, a, d, be);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
